// File: rtl/control_unit_if.sv
// control_unit_if
// Groups the opcode handshake and the registered decode outputs of the
// control unit into one bundle.
//   En           - pipeline-advance strobe (master -> slave)
//   Opcode       - 3-bit instruction opcode (master -> slave)
//   En_write_reg - registered accumulator/register-file write enable
//   En_write_mem - registered data-memory write enable
//   ALU_OP       - registered ALU operation code
//   Halted       - sticky halt flag, only when CONTROL_UNIT_HALT_EN is defined
// Modports: master (instruction side / testbench), slave (control_unit).
interface control_unit_if;
  logic       En;
  logic [2:0] Opcode;
  logic       En_write_reg;
  logic       En_write_mem;
  logic [2:0] ALU_OP;

`ifdef CONTROL_UNIT_HALT_EN
  logic       Halted;

  modport master (
    output En, Opcode,
    input  En_write_reg, En_write_mem, ALU_OP, Halted
  );

  modport slave (
    input  En, Opcode,
    output En_write_reg, En_write_mem, ALU_OP, Halted
  );
`else
  modport master (
    output En, Opcode,
    input  En_write_reg, En_write_mem, ALU_OP
  );

  modport slave (
    input  En, Opcode,
    output En_write_reg, En_write_mem, ALU_OP
  );
`endif
endinterface

// File: rtl/control_unit.sv
// control_unit
// Opcode decoder for the 8-bit CPU. On every rising Clk edge where En=1 the
// opcode is decoded into registered write enables for the register file and
// data memory, and the opcode itself is registered as the ALU operation.
// While En=0 the outputs hold. All outputs come straight from flops.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous, active-high; clears all state immediately
//   bus   - control_unit_if.slave (En, Opcode in; En_write_reg,
//           En_write_mem, ALU_OP and optionally Halted out)
// Optional feature macro: CONTROL_UNIT_HALT_EN
//   Defined   - an accepted HLT (opcode 000) sets a sticky Halted flag and
//               freezes all outputs until Reset.
//   Undefined - HLT is an ordinary no-write decode; no Halted port.
module control_unit #(
  parameter int OPCODE_W = 3,
  parameter int ALU_OP_W = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  control_unit_if.slave bus
);

  logic [OPCODE_W-1:0] opcode;
  logic                dec_reg;
  logic                dec_mem;
  logic [ALU_OP_W-1:0] dec_alu;
  logic                load;

  logic                reg_q;
  logic                mem_q;
  logic [ALU_OP_W-1:0] alu_q;

  assign opcode = bus.Opcode;

  // Decode table. Only STO writes memory and only ADD/AND/XOR/LDA write the
  // register file, so the two enables can never be high together. Any
  // unknown opcode value lands in the default arm and behaves like 000.
  always_comb begin
    dec_reg = 1'b0;
    dec_mem = 1'b0;
    dec_alu = '0;
    case (opcode)
      3'b000, 3'b001, 3'b111: begin
        dec_alu = opcode;
      end
      3'b010, 3'b011, 3'b100, 3'b101: begin
        dec_reg = 1'b1;
        dec_alu = opcode;
      end
      3'b110: begin
        dec_mem = 1'b1;
        dec_alu = opcode;
      end
      default: begin
        dec_reg = 1'b0;
        dec_mem = 1'b0;
        dec_alu = '0;
      end
    endcase
  end

`ifdef CONTROL_UNIT_HALT_EN
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Halt state register; only Reset leaves HALTED.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The HLT that causes the halt is itself loaded at the same edge, so the
  // frozen outputs show the HLT decode (no writes, ALU_OP=000).
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      RUN: begin
        load = bus.En;
        if (bus.En && (opcode == 3'b000)) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        load = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign bus.Halted = (state_q == HALTED);
`else
  assign load = bus.En;
`endif

  // Output registers: load the decode on an accepted edge, otherwise hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      reg_q <= 1'b0;
      mem_q <= 1'b0;
      alu_q <= '0;
    end else if (load) begin
      reg_q <= dec_reg;
      mem_q <= dec_mem;
      alu_q <= dec_alu;
    end
  end

  assign bus.En_write_reg = reg_q;
  assign bus.En_write_mem = mem_q;
  assign bus.ALU_OP       = alu_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Self-checking bench for control_unit: directed reset/hold/decode vectors
// from a table, hand-written multi-cycle reset and halt sequences, and a
// randomized run compared against a table-based reference model.
// Honours CONTROL_UNIT_HALT_EN the same way the design does.
module tb_control_unit;

  logic Clk;
  logic Reset;

  int checks;
  int failures;

  control_unit_if bus ();

  control_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  typedef struct {
    string      name;
    bit         en;
    logic [2:0] op;
    bit         e_reg;
    bit         e_mem;
    logic [2:0] e_alu;
  } vec_t;

  vec_t vecs[$];

  // Specification decode table indexed by opcode.
  bit reg_tbl [0:7];
  bit mem_tbl [0:7];

  // Reference model state.
  bit         m_reg;
  bit         m_mem;
  logic [2:0] m_alu;
  bit         m_halt;

  // Compare every output against the expected values as one record.
  task automatic checkOutput(input string name, input bit e_reg, input bit e_mem,
                             input logic [2:0] e_alu, input bit e_halt);
    logic act_halt;
`ifdef CONTROL_UNIT_HALT_EN
    act_halt = bus.Halted;
`else
    act_halt = 1'b0;
`endif
    checks++;
    if ({bus.En_write_reg, bus.En_write_mem, bus.ALU_OP, act_halt} !==
        {e_reg, e_mem, e_alu, e_halt}) begin
      failures++;
      $display("[TB] FAIL %s: got reg=%b mem=%b alu=%b halt=%b, want reg=%b mem=%b alu=%b halt=%b",
               name, bus.En_write_reg, bus.En_write_mem, bus.ALU_OP, act_halt,
               e_reg, e_mem, e_alu, e_halt);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, settle.
  task automatic applyStimulus(input bit rst, input bit en, input logic [2:0] op);
    @(negedge Clk);
    Reset     = rst;
    bus.En     = en;
    bus.Opcode = op;
    @(posedge Clk);
    #1;
  endtask

  // Reference model: apply one edge's worth of the specification's rules.
  task automatic modelStep(input bit rst, input bit en, input logic [2:0] op);
    bit frozen;
`ifdef CONTROL_UNIT_HALT_EN
    frozen = m_halt;
`else
    frozen = 1'b0;
`endif
    if (rst) begin
      m_reg  = 1'b0;
      m_mem  = 1'b0;
      m_alu  = 3'd0;
      m_halt = 1'b0;
    end else if (en && !frozen) begin
      m_reg = reg_tbl[op];
      m_mem = mem_tbl[op];
      m_alu = op;
`ifdef CONTROL_UNIT_HALT_EN
      if (op == 3'd0) m_halt = 1'b1;
`endif
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reg_tbl  = '{0, 0, 1, 1, 1, 1, 0, 0};
    mem_tbl  = '{0, 0, 0, 0, 0, 0, 1, 0};

    vecs.push_back('{"xor",    1'b1, 3'b100, 1'b1, 1'b0, 3'b100});
    vecs.push_back('{"add",    1'b1, 3'b010, 1'b1, 1'b0, 3'b010});
    vecs.push_back('{"lda",    1'b1, 3'b101, 1'b1, 1'b0, 3'b101});
    vecs.push_back('{"sto",    1'b1, 3'b110, 1'b0, 1'b1, 3'b110});
    vecs.push_back('{"and",    1'b1, 3'b011, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{"hold",   1'b0, 3'b100, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{"hold2",  1'b0, 3'b110, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{"lda2",   1'b1, 3'b101, 1'b1, 1'b0, 3'b101});
    vecs.push_back('{"skz",    1'b1, 3'b001, 1'b0, 1'b0, 3'b001});
    vecs.push_back('{"sto2",   1'b1, 3'b110, 1'b0, 1'b1, 3'b110});
    vecs.push_back('{"jmp",    1'b1, 3'b111, 1'b0, 1'b0, 3'b111});

    // Reset pulse 5..25 ns with En=1 applied, so Reset must win.
    Reset      = 1'b0;
    bus.En     = 1'b1;
    bus.Opcode = 3'b010;
    #5 Reset = 1'b1;
    #10 checkOutput("reset_active", 1'b0, 1'b0, 3'b000, 1'b0);
    #10;
    Reset  = 1'b0;
    bus.En = 1'b0;
    @(posedge Clk);
    #1 checkOutput("post_reset_idle", 1'b0, 1'b0, 3'b000, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].en, vecs[i].op);
      checkOutput(vecs[i].name, vecs[i].e_reg, vecs[i].e_mem, vecs[i].e_alu, 1'b0);
    end

    // Asynchronous reset mid-operation, then priority over En, then hold.
    applyStimulus(1'b0, 1'b1, 3'b110);
    checkOutput("sto_before_reset", 1'b0, 1'b1, 3'b110, 1'b0);
    @(negedge Clk);
    #3 Reset = 1'b1;
    #1 checkOutput("async_reset", 1'b0, 1'b0, 3'b000, 1'b0);
    bus.En     = 1'b1;
    bus.Opcode = 3'b101;
    @(posedge Clk);
    #1 checkOutput("reset_priority", 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b101);
    checkOutput("reset_release_hold", 1'b0, 1'b0, 3'b000, 1'b0);

    // HLT followed by STO.
    applyStimulus(1'b0, 1'b1, 3'b101);
    applyStimulus(1'b0, 1'b1, 3'b000);
`ifdef CONTROL_UNIT_HALT_EN
    checkOutput("hlt_sets_halt", 1'b0, 1'b0, 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b110);
    checkOutput("halt_freezes", 1'b0, 1'b0, 3'b000, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b110);
    checkOutput("reset_clears_halt", 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b110);
    checkOutput("run_after_halt", 1'b0, 1'b1, 3'b110, 1'b0);
`else
    checkOutput("hlt_plain", 1'b0, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b110);
    checkOutput("sto_after_hlt", 1'b0, 1'b1, 3'b110, 1'b0);
`endif

    // Randomized run against the reference model, starting from reset.
    for (int i = 0; i < 300; i++) begin
      bit         rst;
      bit         en;
      logic [2:0] op;
      rst = (i == 0) || ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 3) != 0);
      op  = 3'($urandom_range(0, 7));
      applyStimulus(rst, en, op);
      modelStep(rst, en, op);
      checkOutput("random", m_reg, m_mem, m_alu, m_halt);
      checks++;
      if (bus.En_write_reg && bus.En_write_mem) begin
        failures++;
        $display("[TB] FAIL exclusive: got reg=%b mem=%b, want not both 1",
                 bus.En_write_reg, bus.En_write_mem);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
